// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus master/slave ports.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

    localparam int ADDR_WIDTH_DEF           = 16;
    localparam int DATA_WIDTH_DEF           = 8;
    localparam int SLAVE_MEM_ADDR_WIDTH_DEF = 12;
    localparam int ACK_TIMEOUT_DEF          = 16;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        WAIT_ACK,
        WDATA,
        RDATA,
        SPLIT,
        DONE
    } bus_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/piso_sipo_shift.sv
// Shift register with parallel load; shifts right, LSB leaves first, new bit enters at MSB.
// Latency: load or shift takes effect on the next clock edge.
// Backpressure: none; shifts only when told to.
module piso_sipo_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    // Load has priority over shift; after WIDTH shifts the first bit in sits at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {ser_in, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/bus_master_port.sv
// Master-side bridge: one parallel request -> arbitrated, LSB-first serial bus transfer.
// Latency: 1 + ADDR_WIDTH + ack wait + DATA_WIDTH (+ svalid gaps / split time) + 1 cycles to resp_valid.
// Backpressure: req_ready low from accept until IDLE; resp_valid is a one-cycle pulse with no ready.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH           = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH           = DATA_WIDTH_DEF,
    parameter int SLAVE_MEM_ADDR_WIDTH = SLAVE_MEM_ADDR_WIDTH_DEF,
    parameter int ACK_TIMEOUT          = ACK_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_mode,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  m_breq,
    input  logic                  m_bgrant,
    output logic                  m_wdata,
    output logic                  m_mode,
    output logic                  m_mvalid,
    input  logic                  m_rdata,
    input  logic                  m_svalid,
    input  logic                  m_ack,
    input  logic                  m_split
);

    localparam int CNT_W = $clog2(max_int(ADDR_WIDTH, DATA_WIDTH));
    localparam int TMR_W = $clog2(ACK_TIMEOUT) + 1;
    // The serial address is the slave-local offset followed by the device select bits.
    localparam int DEV_W = ADDR_WIDTH - SLAVE_MEM_ADDR_WIDTH;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(SLAVE_MEM_ADDR_WIDTH + DEV_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);

    bus_state_t            state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [TMR_W-1:0]      tmr;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  mode_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic                  dat_in;

    logic accept, cnt_clr, cnt_inc, tmr_clr, err_set, dat_shift;

    // Write data leaves from the LSB; read data enters at the MSB so it lands LSB-first.
    assign dat_in = (state == RDATA) && m_rdata;
    assign m_mode = (state != IDLE) && mode_q;

    piso_sipo_shift #(
        .WIDTH(DATA_WIDTH)
    ) u_dat_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (req_mode ? req_wdata : '0),
        .shift    (dat_shift),
        .ser_in   (dat_in),
        .q        (dat_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latch, bit counter, ack timer and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            mode_q <= MODE_READ;
            err_q  <= 1'b0;
            cnt    <= '0;
            tmr    <= '0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                mode_q <= req_mode;
                err_q  <= 1'b0;
            end else if (err_set) begin
                err_q  <= 1'b1;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (tmr_clr) begin
                tmr <= '0;
            end else if (state == WAIT_ACK && tmr != '1) begin
                tmr <= tmr + TMR_W'(1);
            end
        end
    end

    // Next state, control strobes and Moore outputs.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        tmr_clr    = 1'b0;
        err_set    = 1'b0;
        dat_shift  = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        m_breq     = 1'b0;
        m_wdata    = 1'b0;
        m_mvalid   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                m_breq = 1'b1;
                if (m_bgrant) begin
                    cnt_clr   = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                m_breq   = 1'b1;
                m_mvalid = 1'b1;
                m_wdata  = addr_q[cnt];
                if (!m_bgrant) begin
                    err_set   = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == ADDR_LAST) begin
                    cnt_clr   = 1'b1;
                    tmr_clr   = 1'b1;
                    state_nxt = WAIT_ACK;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_ACK: begin
                m_breq = 1'b1;
                if (!m_bgrant) begin
                    err_set   = 1'b1;
                    state_nxt = DONE;
                end else if (m_ack) begin
                    state_nxt = (mode_q == MODE_WRITE) ? WDATA : RDATA;
                end else if (tmr == TMR_LAST) begin
                    err_set   = 1'b1;
                    state_nxt = DONE;
                end
            end
            WDATA: begin
                m_breq   = 1'b1;
                m_mvalid = 1'b1;
                m_wdata  = dat_q[0];
                if (!m_bgrant) begin
                    err_set   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    dat_shift = 1'b1;
                    if (cnt == DATA_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            RDATA: begin
                m_breq = 1'b1;
                // A split or a lost grant parks the transfer; the bit count is kept.
                if (m_split || !m_bgrant) begin
                    state_nxt = SPLIT;
                end else if (m_svalid) begin
                    dat_shift = 1'b1;
                    if (cnt == DATA_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            SPLIT: begin
                m_breq = 1'b1;
                if (m_bgrant && !m_split) begin
                    state_nxt = RDATA;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_rdata = dat_q;
                resp_err   = err_q;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
